pmod_i2s2_stream: RTL
=====================

# pmod_i2s2_stream

Parametrised full-duplex I2S master for the Pmod I2S2 codec board (CS5343 ADC, CS4344 DAC). It generates mclk, lrck and sclk from the system clock, deserialises line-in stereo samples onto a valid-pulse output, and serialises line-out samples from a valid/ready input with a one-frame buffer. It sits between the Pmod pins and the vocoder's sample-rate datapath. It generalises the receive-only pmod_i2s2 with configurable sample width, clock ratios, a mono mode, a transmit path, and underrun reporting.

## Interface
- SAMPLE_WIDTH, 24, bits per sample; legal range 8..31 (slot is fixed at 32 sclk periods).
- MCLK_HALF, 4, clk_in cycles per mclk half-period.
- SCLK_HALF, 16, clk_in cycles per sclk half-period; must be a multiple of MCLK_HALF (default gives mclk = 256·fs).
- MONO, 0, 1 = mono: the left channel is duplicated on RX and TX.
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- mclk_out / lrck_out / sclk_out  output  1  codec clocks, shared by ADC and DAC.
- lin_sdout_in  input  1  ADC serial data.
- lout_sdin_out  output  1  DAC serial data.
- rx_left_out / rx_right_out  output  SAMPLE_WIDTH  last complete received frame, two's complement.
- rx_valid_out  output  1  one-cycle pulse when the rx_* samples update.
- tx_left_in / tx_right_in  input  SAMPLE_WIDTH  samples to transmit.
- tx_valid_in  input  1 / tx_ready_out  output  1  transmit handshake.
- tx_underrun_out  output  1  one-cycle pulse when a frame starts with the buffer empty.

## Operation
- Free-running frame_cnt counts 0..FRAME-1, where FRAME = 128·SCLK_HALF, then wraps to 0. Period index p = frame_cnt / (2·SCLK_HALF), range 0..63. Slot bit s = p mod 32.
- All clock outputs are registered and match frame_cnt in the same cycle:
  - mclk_out = (frame_cnt / MCLK_HALF) odd.
  - sclk_out = (frame_cnt mod 2·SCLK_HALF) ≥ SCLK_HALF.
  - lrck_out = p ≥ 32; low selects left.
- Rise cycle: frame_cnt mod 2·SCLK_HALF == SCLK_HALF. Fall cycle: frame_cnt mod 2·SCLK_HALF == 0.
- Standard I2S format with a one-bit delay:
  - s = 0 is the delay bit.
  - s = 1..SAMPLE_WIDTH carry the sample MSB first.
  - Remaining slot bits are 0 on TX and ignored on RX.
- RX path:
  - lin_sdout_in is sampled at the end of each rise cycle with s in 1..SAMPLE_WIDTH, into a left or right shifter selected by lrck.
  - After the right LSB is sampled, both outputs update together and rx_valid_out pulses.
  - MONO=1: rx_right_out = the received left sample.
- TX path:
  - One-entry buffer; tx_ready_out = buffer empty. The buffer is written on tx_valid_in && tx_ready_out.
  - Load cycle is frame_cnt == FRAME-1:
    - Buffer full: copy it into the TX shifters and mark the buffer empty.
    - Buffer empty: load zeros and flag an underrun.
  - lout_sdin_out takes each new bit value in fall cycles. Before the first load after reset it transmits 0.
  - MONO=1: the right slot transmits the left sample; tx_right_in is ignored.
- Simultaneous events:
  - A handshake in the load cycle with an empty buffer is not bypassed. The underrun is still flagged and the sample goes out in the following frame.
  - The buffer is never full and accepting in the same cycle.
- Reset, including mid-frame:
  - frame_cnt = 0 and the buffer is emptied; any partial RX sample is discarded.
  - Outputs: all clocks 0, lout_sdin_out 0, rx_* 0, rx_valid_out 0, tx_underrun_out 0, tx_ready_out 1.

## Timing
- Delays:
  - rx_valid_out is high in the cycle after the rise cycle of p = 32+SAMPLE_WIDTH. With defaults: rise at frame_cnt 1808, valid at 1809, for exactly one cycle per frame.
  - The rx_* samples change in that same cycle and hold until the next frame.
  - tx_underrun_out is high in the frame_cnt == 0 cycle.
  - tx_ready_out rises in the frame_cnt == 0 cycle after a full-buffer load.
- TX latency: a sample accepted in frame N (before its load cycle) is transmitted in frame N+1. Its MSB appears at the fall cycle of p = 1.
- The first complete RX frame is frame 0 after reset release.

## Test plan
Benches use MCLK_HALF=1, SCLK_HALF=2 (FRAME = 256, rise cycle of period p = 4p+2) and SAMPLE_WIDTH=24 unless stated.

- Clock generation: release reset and observe one frame.
  - Required: mclk period 2 cycles, sclk period 4 cycles.
  - lrck_out low for frame_cnt 0..127 and high for 128..255.
  - Exactly 64 sclk rises per frame.
- RX: an I2S ADC model drives left 0xF0AA11, right 0x0F55EE.
  - Required: rx_left_out = 0xF0AA11, rx_right_out = 0x0F55EE.
  - rx_valid_out high for exactly one cycle at frame_cnt 227 of every frame.
- TX: push left 0xA5A5A5, right 0x5A5A5A during frame 0.
  - Required: tx_ready_out goes low the next cycle and rises again at frame_cnt 0.
  - Decoding lout_sdin_out in frame 1 gives the same pair.
  - No tx_underrun_out pulse.
- Underrun: push nothing in frame 0, then assert tx_valid_in exactly at frame_cnt 255.
  - Required: frame 1 transmits all zeros and tx_underrun_out pulses at frame 1, frame_cnt 0.
  - The pushed sample is transmitted in frame 2.
- MONO=1: ADC left = 0x123456, right = 0x654321; TX left = 0x00FF00, right = 0xFFFFFF.
  - Required: rx_left_out = rx_right_out = 0x123456.
  - Both DAC slots carry 0x00FF00.
- Reset mid-frame: assert rst_in low at frame_cnt 100 with a buffered TX sample.
  - Required: all outputs take their reset values immediately (asynchronously).
  - No rx_valid_out pulse for the aborted frame; the buffered sample is never transmitted.
  - After release, frame_cnt restarts at 0 and the next complete frame is received correctly.

Source files
------------

// File: rtl/pmod_i2s2_stream.sv
// Full-duplex I2S master for the Pmod I2S2: generates mclk/lrck/sclk, deserialises line-in
// stereo frames and serialises line-out frames from a one-entry valid/ready buffer.
module pmod_i2s2_stream #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int MCLK_HALF    = 4,
    parameter int SCLK_HALF    = 16,
    parameter int MONO         = 0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    output logic                    mclk_out,
    output logic                    lrck_out,
    output logic                    sclk_out,
    input  logic                    lin_sdout_in,
    output logic                    lout_sdin_out,
    output logic [SAMPLE_WIDTH-1:0] rx_left_out,
    output logic [SAMPLE_WIDTH-1:0] rx_right_out,
    output logic                    rx_valid_out,
    input  logic [SAMPLE_WIDTH-1:0] tx_left_in,
    input  logic [SAMPLE_WIDTH-1:0] tx_right_in,
    input  logic                    tx_valid_in,
    output logic                    tx_ready_out,
    output logic                    tx_underrun_out
);

    localparam int         PHASE_N   = 2 * SCLK_HALF;
    localparam int         PH_W      = (PHASE_N > 2) ? $clog2(PHASE_N) : 1;
    localparam int         MD_W      = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_WIDTH);

    // frame_cnt is kept split as {period, phase}; period is the sclk period index 0..63
    logic [PH_W-1:0] phase, phase_nx;
    logic [5:0]      period, period_nx;
    logic [MD_W-1:0] mdiv;
    logic            last_phase, rise, load, rx_slot, tx_slot_nx;

    logic [SAMPLE_WIDTH-1:0] rx_sh_l, rx_sh_r;
    logic [SAMPLE_WIDTH-1:0] buf_l, buf_r, tx_sh_l, tx_sh_r;

    always_comb begin
        last_phase = (phase == PH_W'(PHASE_N - 1));
        phase_nx   = last_phase ? '0 : phase + PH_W'(1);
        period_nx  = last_phase ? period + 6'd1 : period;
        rise       = (phase == PH_W'(SCLK_HALF));
        load       = last_phase && (period == 6'd63);
        rx_slot    = (period[4:0] != 5'd0) && (period[4:0] <= LAST_SLOT);
        tx_slot_nx = (period_nx[4:0] != 5'd0) && (period_nx[4:0] <= LAST_SLOT);
    end

    // Clock outputs are derived from the next count so they line up with frame_cnt.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase    <= '0;
            period   <= '0;
            mdiv     <= '0;
            mclk_out <= 1'b0;
            sclk_out <= 1'b0;
            lrck_out <= 1'b0;
        end else begin
            phase    <= phase_nx;
            period   <= period_nx;
            sclk_out <= (phase_nx >= PH_W'(SCLK_HALF));
            lrck_out <= period_nx[5];
            if (mdiv == MD_W'(MCLK_HALF - 1)) begin
                mdiv     <= '0;
                mclk_out <= ~mclk_out;
            end else begin
                mdiv <= mdiv + MD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_sh_l      <= '0;
            rx_sh_r      <= '0;
            rx_left_out  <= '0;
            rx_right_out <= '0;
            rx_valid_out <= 1'b0;
        end else begin
            rx_valid_out <= 1'b0;
            if (rise && rx_slot) begin
                if (!period[5]) begin
                    rx_sh_l <= {rx_sh_l[SAMPLE_WIDTH-2:0], lin_sdout_in};
                end else if (period[4:0] == LAST_SLOT) begin
                    rx_left_out  <= rx_sh_l;
                    rx_right_out <= (MONO != 0) ? rx_sh_l
                                                : {rx_sh_r[SAMPLE_WIDTH-2:0], lin_sdout_in};
                    rx_valid_out <= 1'b1;
                end else begin
                    rx_sh_r <= {rx_sh_r[SAMPLE_WIDTH-2:0], lin_sdout_in};
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            buf_l           <= '0;
            buf_r           <= '0;
            tx_sh_l         <= '0;
            tx_sh_r         <= '0;
            tx_ready_out    <= 1'b1;
            tx_underrun_out <= 1'b0;
            lout_sdin_out   <= 1'b0;
        end else begin
            tx_underrun_out <= 1'b0;
            if (tx_valid_in && tx_ready_out) begin
                buf_l        <= tx_left_in;
                buf_r        <= tx_right_in;
                tx_ready_out <= 1'b0;
            end
            if (last_phase) begin
                if (!tx_slot_nx) begin
                    lout_sdin_out <= 1'b0;
                end else if (period_nx[5]) begin
                    lout_sdin_out <= tx_sh_r[SAMPLE_WIDTH-1];
                    tx_sh_r       <= tx_sh_r << 1;
                end else begin
                    lout_sdin_out <= tx_sh_l[SAMPLE_WIDTH-1];
                    tx_sh_l       <= tx_sh_l << 1;
                end
            end
            // An empty-buffer load does not bypass a same-cycle write; that sample waits a frame.
            if (load) begin
                if (!tx_ready_out) begin
                    tx_sh_l      <= buf_l;
                    tx_sh_r      <= (MONO != 0) ? buf_l : buf_r;
                    tx_ready_out <= 1'b1;
                end else begin
                    tx_sh_l         <= '0;
                    tx_sh_r         <= '0;
                    tx_underrun_out <= 1'b1;
                end
            end
        end
    end

endmodule
